tpu_host_sequencer: RTL and testbench
=====================================

TPU_HOST_SEQUENCER -- requirements
Module: tpu_host_sequencer

Interface
REQ-001 SHALL: clk  input  1  rising-edge clock; reset  input  1  reset, synchronous, active-high.
REQ-002 SHALL: job_valid/job_ready  in/out  1/1  job descriptor handshake; job_k, job_m, job_n  input  8 each  GEMM dimensions; job_offset  input  9  input offset.
REQ-003 SHALL: job_a_cnt, job_b_cnt, job_c_cnt  input  13 each  word counts, legal range 1..4096; 0 treated as 1.
REQ-004 SHALL: a_valid/a_ready  in/out  1/1, a_data  input  32  A-operand stream; b_valid/b_ready, b_data  same for B.
REQ-005 SHALL: func  output  7  command code; state  input  2  compute-controller status (3 = compute finished).
REQ-006 SHALL: InputOffset  output  9; K, M, N  output  8 each; A_index, B_index, C_index  output  12 each; A_data_in, B_data_in  output  32.
REQ-007 SHALL: C_data_out  input  128  C buffer read data, valid one cycle after C_index is registered.
REQ-008 SHALL: c_valid/c_ready  out/in  1/1, c_data  output  128  result stream; busy  output  1; done  output  1  one-cycle pulse; err  output  1  sticky watchdog flag.

Function
REQ-009 SHALL: FSM states IDLE, LOAD_A, LOAD_B, SET_OFS, COMPUTE, RD_ADDR, RD_WAIT, RD_OUT, FINISH; all outputs registered.
REQ-010 SHALL: job_ready = 1 only in IDLE; job_valid&&job_ready latches descriptor into K/M/N/InputOffset/counts and moves to LOAD_A; busy = 1 in every state except IDLE.
REQ-011 SHALL: in LOAD_A a_ready = 1; accepted word at cycle t -> at t+1 func=1, A_index=word number (0-based), A_data_in=a_data; cycles with no accepted word drive func=0.
REQ-012 SHALL: after word job_a_cnt-1 accepted, go to LOAD_B; LOAD_B identical with func=2, B_index, B_data_in, b_ready; after job_b_cnt words go to SET_OFS.
REQ-013 SHALL: SET_OFS drives func=5 for exactly 2 cycles, then COMPUTE.
REQ-014 SHALL: COMPUTE drives func=3 continuously; after at least 2 cycles in COMPUTE, state==3 sampled on rising edge -> RD_ADDR with func=0.
REQ-015 SHALL: read loop per C entry i: RD_ADDR registers C_index=i (func=0); RD_WAIT one cycle; RD_OUT captures C_data_out into c_data, c_valid=1 held stable until c_ready.
REQ-016 SHALL: c_valid&&c_ready -> next entry (RD_ADDR) or, after job_c_cnt entries, FINISH; minimum 3 cycles per entry.
REQ-017 SHALL: FINISH pulses done for one cycle, func=0, returns to IDLE.
REQ-018 SHALL: a_valid during non-LOAD_A states, b_valid outside LOAD_B, job_valid outside IDLE are ignored (ready low, no side effects).
REQ-019 SHALL: counters 13-bit; index outputs are counter[11:0]; count 4096 produces indices 0..4095 without wrap into 0.
REQ-020 SHALL: back-to-back jobs: job_ready asserts the cycle after FINISH.

Reset
REQ-021 SHALL: reset, including mid-job, returns FSM to IDLE next edge; func, K, M, N, InputOffset, all indices, data outputs, c_data = 0; a_ready, b_ready, c_valid, done, err = 0; busy = 0; job_ready = 1 after reset deasserts.
REQ-022 SHALL: words partially loaded before reset are abandoned; no resume.

Configuration
REQ-023 SHALL: macro TPU_SEQ_WATCHDOG_EN defined -> 20-bit counter in COMPUTE; reaching 1048575 cycles without state==3 sets err=1, forces func=0, pulses done, returns IDLE; err clears only on reset or next job acceptance.
REQ-024 SHALL: TPU_SEQ_WATCHDOG_EN undefined -> COMPUTE waits indefinitely; err tied 0; no counter logic.

Verification
REQ-025 SHALL: job K=4,M=4,N=4,ofs=128, a_cnt=4,b_cnt=4,c_cnt=1, continuous streams -> func=1 indices 0..3, func=2 indices 0..3, func=5 two cycles, func=3 until state=3, C_index=0, c_data equals C_data_out, done pulse.
REQ-026 SHALL: a_valid toggled 1,0,1,0 -> func=1 only on cycles following accepted words, A_index contiguous 0..3.
REQ-027 SHALL: c_cnt=3, c_ready held low 5 cycles on entry 1 -> c_data stable, C_index stays 1, entries 0,1,2 delivered in order.
REQ-028 SHALL: reset asserted during LOAD_B word 2 -> next cycle all outputs at reset values, job_ready=1; new job runs from A_index 0.
REQ-029 SHALL: a_cnt=4096 -> last A_index=4095, then LOAD_B.
REQ-030 SHALL: TPU_SEQ_WATCHDOG_EN defined, state never 3 -> err=1 and done after 1048575 COMPUTE cycles; undefined -> busy stays 1.

Source files
------------

// File: rtl/tpu_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tpu_host_sequencer
// Brief    : Host-side job sequencer: streams A/B operands into the TPU core,
//            starts compute, then drains C results over a valid/ready stream.
//            Optional compute watchdog enabled by defining TPU_SEQ_WATCHDOG_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tpu_host_sequencer (
    input  logic         clk,
    input  logic         reset,
    input  logic         job_valid,
    output logic         job_ready,
    input  logic [7:0]   job_k,
    input  logic [7:0]   job_m,
    input  logic [7:0]   job_n,
    input  logic [8:0]   job_offset,
    input  logic [12:0]  job_a_cnt,
    input  logic [12:0]  job_b_cnt,
    input  logic [12:0]  job_c_cnt,
    input  logic         a_valid,
    output logic         a_ready,
    input  logic [31:0]  a_data,
    input  logic         b_valid,
    output logic         b_ready,
    input  logic [31:0]  b_data,
    output logic [6:0]   func,
    input  logic [1:0]   state,
    output logic [8:0]   InputOffset,
    output logic [7:0]   K,
    output logic [7:0]   M,
    output logic [7:0]   N,
    output logic [11:0]  A_index,
    output logic [11:0]  B_index,
    output logic [11:0]  C_index,
    output logic [31:0]  A_data_in,
    output logic [31:0]  B_data_in,
    input  logic [127:0] C_data_out,
    output logic         c_valid,
    input  logic         c_ready,
    output logic [127:0] c_data,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam logic [6:0] c_FUNC_NOP     = 7'd0;
    localparam logic [6:0] c_FUNC_LOAD_A  = 7'd1;
    localparam logic [6:0] c_FUNC_LOAD_B  = 7'd2;
    localparam logic [6:0] c_FUNC_COMPUTE = 7'd3;
    localparam logic [6:0] c_FUNC_SET_OFS = 7'd5;
    localparam logic [1:0] c_CC_FINISHED  = 2'd3;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_LOAD_A  = 4'd1,
        S_LOAD_B  = 4'd2,
        S_SET_OFS = 4'd3,
        S_COMPUTE = 4'd4,
        S_RD_ADDR = 4'd5,
        S_RD_WAIT = 4'd6,
        S_RD_OUT  = 4'd7,
        S_FINISH  = 4'd8
    } fsm_t;

    fsm_t           r_fsm;
    logic           r_job_ready;
    logic           r_a_ready;
    logic           r_b_ready;
    logic [6:0]     r_func;
    logic [7:0]     r_k;
    logic [7:0]     r_m;
    logic [7:0]     r_n;
    logic [8:0]     r_ofs;
    logic [11:0]    r_a_idx;
    logic [11:0]    r_b_idx;
    logic [11:0]    r_c_idx;
    logic [31:0]    r_a_din;
    logic [31:0]    r_b_din;
    logic           r_c_valid;
    logic [127:0]   r_c_data;
    logic           r_busy;
    logic           r_done;
    logic [12:0]    r_a_last;
    logic [12:0]    r_b_last;
    logic [12:0]    r_c_last;
    logic [12:0]    r_cnt;
    logic [1:0]     r_settle;
    logic [12:0]    w_cnt_inc;

`ifdef TPU_SEQ_WATCHDOG_EN
    // r_wd equals k on the (k+1)-th COMPUTE cycle, so this trips on cycle 1048575.
    localparam logic [19:0] c_WD_LAST = 20'd1048574;
    logic           r_err;
    logic [19:0]    r_wd;
    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign w_cnt_inc = r_cnt + 13'd1;

    // A zero count is treated as a single word, so the terminal index is count-1 floored at 0.
    function automatic logic [12:0] f_last(input logic [12:0] cnt);
        return (cnt == 13'd0) ? 13'd0 : cnt - 13'd1;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fsm       <= S_IDLE;
            r_job_ready <= 1'b1;
            r_a_ready   <= 1'b0;
            r_b_ready   <= 1'b0;
            r_func      <= c_FUNC_NOP;
            r_k         <= 8'd0;
            r_m         <= 8'd0;
            r_n         <= 8'd0;
            r_ofs       <= 9'd0;
            r_a_idx     <= 12'd0;
            r_b_idx     <= 12'd0;
            r_c_idx     <= 12'd0;
            r_a_din     <= 32'd0;
            r_b_din     <= 32'd0;
            r_c_valid   <= 1'b0;
            r_c_data    <= 128'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_a_last    <= 13'd0;
            r_b_last    <= 13'd0;
            r_c_last    <= 13'd0;
            r_cnt       <= 13'd0;
            r_settle    <= 2'd0;
`ifdef TPU_SEQ_WATCHDOG_EN
            r_err       <= 1'b0;
            r_wd        <= 20'd0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (job_valid && r_job_ready) begin
                        r_k         <= job_k;
                        r_m         <= job_m;
                        r_n         <= job_n;
                        r_ofs       <= job_offset;
                        r_a_last    <= f_last(job_a_cnt);
                        r_b_last    <= f_last(job_b_cnt);
                        r_c_last    <= f_last(job_c_cnt);
                        r_cnt       <= 13'd0;
                        r_job_ready <= 1'b0;
                        r_a_ready   <= 1'b1;
                        r_busy      <= 1'b1;
                        r_fsm       <= S_LOAD_A;
`ifdef TPU_SEQ_WATCHDOG_EN
                        r_err       <= 1'b0;
`endif
                    end
                end
                S_LOAD_A: begin
                    if (a_valid && r_a_ready) begin
                        r_func  <= c_FUNC_LOAD_A;
                        r_a_idx <= r_cnt[11:0];
                        r_a_din <= a_data;
                        if (r_cnt == r_a_last) begin
                            r_cnt     <= 13'd0;
                            r_a_ready <= 1'b0;
                            r_b_ready <= 1'b1;
                            r_fsm     <= S_LOAD_B;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_func <= c_FUNC_NOP;
                    end
                end
                S_LOAD_B: begin
                    if (b_valid && r_b_ready) begin
                        r_func  <= c_FUNC_LOAD_B;
                        r_b_idx <= r_cnt[11:0];
                        r_b_din <= b_data;
                        if (r_cnt == r_b_last) begin
                            r_cnt     <= 13'd0;
                            r_b_ready <= 1'b0;
                            r_settle  <= 2'd0;
                            r_fsm     <= S_SET_OFS;
                        end else begin
                            r_cnt <= w_cnt_inc;
                        end
                    end else begin
                        r_func <= c_FUNC_NOP;
                    end
                end
                S_SET_OFS: begin
                    r_func <= c_FUNC_SET_OFS;
                    if (r_settle == 2'd1) begin
                        r_settle <= 2'd0;
                        r_fsm    <= S_COMPUTE;
`ifdef TPU_SEQ_WATCHDOG_EN
                        r_wd     <= 20'd0;
`endif
                    end else begin
                        r_settle <= r_settle + 2'd1;
                    end
                end
                S_COMPUTE: begin
                    // The first two COMPUTE cycles ignore a stale "finished" status from the core.
                    if (r_settle == 2'd2 && state == c_CC_FINISHED) begin
                        r_func  <= c_FUNC_NOP;
                        r_cnt   <= 13'd0;
                        r_c_idx <= 12'd0;
                        r_fsm   <= S_RD_ADDR;
                    end
`ifdef TPU_SEQ_WATCHDOG_EN
                    else if (r_wd == c_WD_LAST) begin
                        r_err       <= 1'b1;
                        r_func      <= c_FUNC_NOP;
                        r_done      <= 1'b1;
                        r_busy      <= 1'b0;
                        r_job_ready <= 1'b1;
                        r_fsm       <= S_IDLE;
                    end
`endif
                    else begin
                        r_func <= c_FUNC_COMPUTE;
                        if (r_settle != 2'd2) begin
                            r_settle <= r_settle + 2'd1;
                        end
`ifdef TPU_SEQ_WATCHDOG_EN
                        r_wd <= r_wd + 20'd1;
`endif
                    end
                end
                S_RD_ADDR: begin
                    r_fsm <= S_RD_WAIT;
                end
                S_RD_WAIT: begin
                    // C buffer read data is valid now, one cycle after C_index was presented.
                    r_c_data  <= C_data_out;
                    r_c_valid <= 1'b1;
                    r_fsm     <= S_RD_OUT;
                end
                S_RD_OUT: begin
                    if (r_c_valid && c_ready) begin
                        r_c_valid <= 1'b0;
                        if (r_cnt == r_c_last) begin
                            r_fsm <= S_FINISH;
                        end else begin
                            r_cnt   <= w_cnt_inc;
                            r_c_idx <= w_cnt_inc[11:0];
                            r_fsm   <= S_RD_ADDR;
                        end
                    end
                end
                S_FINISH: begin
                    r_done      <= 1'b1;
                    r_func      <= c_FUNC_NOP;
                    r_busy      <= 1'b0;
                    r_job_ready <= 1'b1;
                    r_fsm       <= S_IDLE;
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    assign job_ready   = r_job_ready;
    assign a_ready     = r_a_ready;
    assign b_ready     = r_b_ready;
    assign func        = r_func;
    assign InputOffset = r_ofs;
    assign K           = r_k;
    assign M           = r_m;
    assign N           = r_n;
    assign A_index     = r_a_idx;
    assign B_index     = r_b_idx;
    assign C_index     = r_c_idx;
    assign A_data_in   = r_a_din;
    assign B_data_in   = r_b_din;
    assign c_valid     = r_c_valid;
    assign c_data      = r_c_data;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tpu_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_tpu_host_sequencer
// Brief    : Directed self-checking bench for tpu_host_sequencer (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_tpu_host_sequencer;

    logic         clk;
    logic         reset;
    logic         job_valid;
    logic         job_ready;
    logic [7:0]   job_k, job_m, job_n;
    logic [8:0]   job_offset;
    logic [12:0]  job_a_cnt, job_b_cnt, job_c_cnt;
    logic         a_valid, a_ready;
    logic [31:0]  a_data;
    logic         b_valid, b_ready;
    logic [31:0]  b_data;
    logic [6:0]   func;
    logic [1:0]   state;
    logic [8:0]   InputOffset;
    logic [7:0]   K, M, N;
    logic [11:0]  A_index, B_index, C_index;
    logic [31:0]  A_data_in, B_data_in;
    logic [127:0] C_data_out;
    logic         c_valid, c_ready;
    logic [127:0] c_data;
    logic         busy, done, err;

    int n_total = 0;
    int n_bad   = 0;

    tpu_host_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .job_valid   (job_valid),
        .job_ready   (job_ready),
        .job_k       (job_k),
        .job_m       (job_m),
        .job_n       (job_n),
        .job_offset  (job_offset),
        .job_a_cnt   (job_a_cnt),
        .job_b_cnt   (job_b_cnt),
        .job_c_cnt   (job_c_cnt),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_data      (a_data),
        .b_valid     (b_valid),
        .b_ready     (b_ready),
        .b_data      (b_data),
        .func        (func),
        .state       (state),
        .InputOffset (InputOffset),
        .K           (K),
        .M           (M),
        .N           (N),
        .A_index     (A_index),
        .B_index     (B_index),
        .C_index     (C_index),
        .A_data_in   (A_data_in),
        .B_data_in   (B_data_in),
        .C_data_out  (C_data_out),
        .c_valid     (c_valid),
        .c_ready     (c_ready),
        .c_data      (c_data),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] cval(input logic [11:0] idx);
        return {idx, 20'hABCDE, 20'h12345, ~idx, 32'hFACE0000 ^ {20'h0, idx}, 32'h0BADF00D};
    endfunction

    // Synchronous-read C buffer: data follows the registered address by one cycle.
    always @(posedge clk) C_data_out <= cval(C_index);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals();
        chk("rst_job_ready", job_ready, 1);
        chk("rst_a_ready", a_ready, 0);
        chk("rst_b_ready", b_ready, 0);
        chk("rst_c_valid", c_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_func", func, 0);
        chk("rst_kmn", {K, M, N}, 0);
        chk("rst_ofs", InputOffset, 0);
        chk("rst_idx", {A_index, B_index, C_index}, 0);
        chk("rst_din", {A_data_in, B_data_in}, 0);
        chk("rst_c_data", c_data, 0);
    endtask

    task automatic start_job(input logic [7:0] k, input logic [7:0] m, input logic [7:0] n,
                             input logic [8:0] ofs, input logic [12:0] ac,
                             input logic [12:0] bc, input logic [12:0] cc);
        chk("job_ready_idle", job_ready, 1);
        job_valid = 1'b1; job_k = k; job_m = m; job_n = n; job_offset = ofs;
        job_a_cnt = ac; job_b_cnt = bc; job_c_cnt = cc;
        tick();
        job_valid = 1'b0; job_k = 8'hFF; job_m = 8'hFF; job_n = 8'hFF; job_offset = 9'h0;
        job_a_cnt = 13'd7; job_b_cnt = 13'd7; job_c_cnt = 13'd7;
        chk("job_busy", busy, 1);
        chk("job_ready_low", job_ready, 0);
        chk("job_K", K, k);
        chk("job_M", M, m);
        chk("job_N", N, n);
        chk("job_ofs", InputOffset, ofs);
        chk("job_a_ready", a_ready, 1);
        chk("job_err", err, 0);
    endtask

    task automatic load_a(input int cnt, input bit toggle, input bit full);
        for (int w = 0; w < cnt; w++) begin
            a_valid = 1'b1; a_data = 32'hA000_0000 + w;
            tick();
            chk("a_func", func, 1);
            chk("a_index", A_index, w[11:0]);
            if (full) chk("a_data", A_data_in, 32'hA000_0000 + w);
            if (toggle) begin
                a_valid = 1'b0; a_data = 32'hDEAD_BEEF;
                tick();
                chk("a_gap_func", func, 0);
                chk("a_gap_index", A_index, w[11:0]);
            end
        end
        a_valid = 1'b0;
        chk("a_ready_after", a_ready, 0);
        chk("b_ready_after_a", b_ready, 1);
    endtask

    task automatic load_b(input int cnt, input bit last);
        for (int w = 0; w < cnt; w++) begin
            b_valid = 1'b1; b_data = 32'hB000_0000 + w;
            tick();
            chk("b_func", func, 2);
            chk("b_index", B_index, w[11:0]);
            chk("b_data", B_data_in, 32'hB000_0000 + w);
        end
        b_valid = 1'b0;
        chk("b_ready_after", b_ready, last ? 0 : 1);
    endtask

    task automatic compute(input int hold);
        tick(); chk("ofs_func1", func, 5);
        tick(); chk("ofs_func2", func, 5);
        state = (hold == 0) ? 2'd3 : 2'd0;
        for (int i = 0; i < ((hold < 2) ? 2 : hold); i++) begin
            tick(); chk("compute_func", func, 3);
        end
        state = 2'd3;
        tick();
        chk("compute_exit_func", func, 0);
        state = 2'd0;
    endtask

    task automatic read_c(input int cnt, input int stall_idx, input int stall_n);
        for (int i = 0; i < cnt; i++) begin
            chk("c_index", C_index, i[11:0]);
            chk("c_valid_addr", c_valid, 0);
            tick(); chk("c_valid_wait", c_valid, 0);
            tick(); chk("c_valid_out", c_valid, 1);
            chk("c_data", c_data, cval(i[11:0]));
            if (i == stall_idx) begin
                c_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    tick();
                    chk("stall_valid", c_valid, 1);
                    chk("stall_data", c_data, cval(i[11:0]));
                    chk("stall_index", C_index, i[11:0]);
                end
            end
            c_ready = 1'b1;
            tick(); chk("c_valid_drop", c_valid, 0);
        end
        chk("done_early", done, 0);
        tick();
        chk("done_pulse", done, 1);
        chk("job_ready_after", job_ready, 1);
        chk("busy_after", busy, 0);
        chk("func_after", func, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; job_valid = 1'b0; job_k = 0; job_m = 0; job_n = 0; job_offset = 0;
        job_a_cnt = 0; job_b_cnt = 0; job_c_cnt = 0;
        a_valid = 1'b0; a_data = 0; b_valid = 1'b0; b_data = 0;
        state = 2'd0; c_ready = 1'b1;
        tick(); tick();
        check_reset_vals();
        reset = 1'b0;
        tick();
        chk("idle_job_ready", job_ready, 1);
        chk("idle_busy", busy, 0);

        // Basic job with continuous streams, immediate compute completion
        start_job(8'd4, 8'd4, 8'd4, 9'd128, 13'd4, 13'd4, 13'd1);
        load_a(4, 1'b0, 1'b1);
        load_b(4, 1'b1);
        compute(0);
        read_c(1, -1, 0);

        // Back-to-back job: gapped A stream, longer compute, stalled C drain
        start_job(8'd2, 8'd3, 8'd5, 9'h1FF, 13'd4, 13'd2, 13'd3);
        chk("done_one_cycle", done, 0);
        load_a(4, 1'b1, 1'b1);
        load_b(2, 1'b1);
        compute(4);
        read_c(3, 1, 5);

        // Maximum A count, zero B/C counts behave as one word
        start_job(8'd1, 8'd1, 8'd1, 9'd0, 13'd4096, 13'd0, 13'd0);
        load_a(4096, 1'b0, 1'b0);
        chk("a_last_index", A_index, 12'd4095);
        load_b(1, 1'b1);
        compute(0);
        read_c(1, -1, 0);

        // Compute that never finishes; stray handshakes must be ignored
        start_job(8'd8, 8'd8, 8'd8, 9'd1, 13'd2, 13'd1, 13'd1);
        load_a(2, 1'b0, 1'b1);
        load_b(1, 1'b1);
        tick(); chk("hang_ofs1", func, 5);
        tick(); chk("hang_ofs2", func, 5);
        a_valid = 1'b1; a_data = 32'h1234_5678;
        b_valid = 1'b1; b_data = 32'h8765_4321;
        job_valid = 1'b1; job_k = 8'd77;
        for (int i = 0; i < 50; i++) begin
            tick();
            chk("hang_busy", busy, 1);
            chk("hang_func", func, 3);
        end
        chk("ign_a_ready", a_ready, 0);
        chk("ign_b_ready", b_ready, 0);
        chk("ign_job_ready", job_ready, 0);
        chk("ign_K", K, 8);
        chk("ign_a_din", A_data_in, 32'hA000_0001);
        chk("ign_b_din", B_data_in, 32'hB000_0000);
        chk("hang_err", err, 0);
        reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0; a_valid = 1'b0; b_valid = 1'b0; job_valid = 1'b0;

        // Reset while B word 2 is being presented; next job restarts cleanly
        start_job(8'd3, 8'd3, 8'd3, 9'd5, 13'd2, 13'd4, 13'd1);
        load_a(2, 1'b0, 1'b1);
        load_b(2, 1'b0);
        b_valid = 1'b1; b_data = 32'hB000_0002; reset = 1'b1;
        tick();
        check_reset_vals();
        reset = 1'b0; b_valid = 1'b0;
        start_job(8'd6, 8'd7, 8'd8, 9'd3, 13'd3, 13'd1, 13'd1);
        load_a(3, 1'b0, 1'b1);
        load_b(1, 1'b1);
        compute(0);
        read_c(1, -1, 0);
        tick();
        chk("done_cleared", done, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
